// File: rtl/aes_ct_out_buffer.sv
// Ciphertext output buffer: captures 128-bit AES blocks into a FIFO and drains them as 32-bit words, MSW first.
// Optional AES_OUT_BUF_ZEROIZE_EN clears freed entries on pop and all storage on reset.
module aes_ct_out_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [127:0]                 in_data,
    input  logic                         in_valid,
    output logic [31:0]                  out_word,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         almost_full,
    output logic                         overflow,
    input  logic                         clear_overflow,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW        = $clog2(DEPTH + 1);
    localparam int unsigned AF_THRESH = DEPTH - AF_LEVEL;

    logic [127:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    word_idx;

    logic          accept_c;
    logic          pop_c;
    logic          full_c;
    logic          push_c;
    logic          drop_c;
    logic [CW-1:0] count_next_c;
    logic [1:0]    word_idx_next_c;
    logic [127:0]  head_c;

    // Handshake decode; a pop on the last word frees a slot for a same-cycle push.
    always_comb begin
        accept_c        = out_valid && out_ready;
        pop_c           = accept_c && (word_idx == 2'd3);
        full_c          = (count == CW'(DEPTH));
        push_c          = in_valid && (!full_c || pop_c);
        drop_c          = in_valid && full_c && !pop_c;
        word_idx_next_c = accept_c ? word_idx + 2'd1 : word_idx;
        count_next_c    = count;
        case ({push_c, pop_c})
            2'b10:   count_next_c = count + CW'(1);
            2'b01:   count_next_c = count - CW'(1);
            default: count_next_c = count;
        endcase
    end

    // Control state; out_valid/out_last/almost_full are registered from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            word_idx    <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            word_idx    <= word_idx_next_c;
            count       <= count_next_c;
            out_valid   <= (count_next_c != '0);
            out_last    <= (count_next_c != '0) && (word_idx_next_c == 2'd3);
            almost_full <= (count_next_c >= CW'(AF_THRESH));
            overflow    <= drop_c || (overflow && !clear_overflow);
        end
    end

`ifdef AES_OUT_BUF_ZEROIZE_EN
    // Storage with scrubbing; a push to the slot being freed overrides the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop_c)  mem[rd_ptr] <= '0;
            if (push_c) mem[wr_ptr] <= in_data;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= in_data;
    end
`endif

    // Word select from the head entry; gated to zero while nothing is valid.
    always_comb begin
        head_c   = mem[rd_ptr];
        out_word = '0;
        if (out_valid) begin
            case (word_idx)
                2'd0:    out_word = head_c[127:96];
                2'd1:    out_word = head_c[95:64];
                2'd2:    out_word = head_c[63:32];
                default: out_word = head_c[31:0];
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ct_out_buffer.sv
// Bench for aes_ct_out_buffer: queue-based reference model checked every cycle plus directed literal checks.
module tb_aes_ct_out_buffer;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned AF_LEVEL = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic         in_valid;
    logic [31:0]  out_word;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         almost_full;
    logic         overflow;
    logic         clear_overflow;
    logic [2:0]   count;

    always #5 clk = ~clk;

    aes_ct_out_buffer #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .almost_full(almost_full), .overflow(overflow),
        .clear_overflow(clear_overflow), .count(count)
    );

    logic [127:0] q[$];
    int           widx;
    bit           m_ovf;
    logic [31:0]  got[$];
    logic [31:0]  samp_word;
    logic [31:0]  prev_word;
    bit           prev_stall;
    int           n_chk;
    int           n_fail;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
        return 32'(b >> (96 - 32 * i));
    endfunction

    // Reference model advanced at each rising edge using the inputs in force before it.
    task automatic model_update();
        bit acc, pop, full, set_ovf;
        if (rst) begin
            q.delete();
            widx       = 0;
            m_ovf      = 1'b0;
            prev_stall = 1'b0;
            return;
        end
        acc        = out_ready && (q.size() != 0);
        pop        = acc && (widx == 3);
        full       = (q.size() == int'(DEPTH));
        prev_stall = (q.size() != 0) && !out_ready;
        prev_word  = samp_word;
        if (acc) got.push_back(samp_word);
        set_ovf = in_valid && full && !pop;
        if (acc) begin
            if (widx == 3) begin
                void'(q.pop_front());
                widx = 0;
            end else begin
                widx++;
            end
        end
        if (in_valid && (!full || pop)) q.push_back(in_data);
        m_ovf = set_ovf || (m_ovf && !clear_overflow);
    endtask

    task automatic compare();
        logic [127:0] h;
        bit v;
        v = (q.size() != 0);
        chk("out_valid", 128'(out_valid), 128'(v));
        chk("count", 128'(count), 128'(q.size()));
        chk("almost_full", 128'(almost_full), 128'(q.size() >= int'(DEPTH - AF_LEVEL)));
        chk("overflow", 128'(overflow), 128'(m_ovf));
        chk("out_last", 128'(out_last), 128'(v && widx == 3));
        if (v) begin
            h = q[0];
            chk("out_word", 128'(out_word), 128'(word_of(h, widx)));
        end else begin
            chk("out_word_idle", 128'(out_word), 128'(0));
        end
        if (prev_stall) chk("stall_hold", 128'(out_word), 128'(prev_word));
        samp_word = out_word;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    localparam logic [127:0] BLK_X = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_A = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
    localparam logic [127:0] BLK_B = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
    localparam logic [127:0] BLK_C = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    localparam logic [127:0] BLK_D = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
    localparam logic [127:0] BLK_E = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;
    localparam logic [127:0] BLK_F = 128'hF0F0F0F0_F1F1F1F1_F2F2F2F2_F3F3F3F3;
    localparam logic [127:0] BLK_G = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    logic [127:0] blks [8];
    logic [127:0] seq4 [4];
    logic [31:0]  exp_x [4];

    initial begin
        n_chk = 0; n_fail = 0;
        widx = 0; m_ovf = 1'b0; samp_word = '0; prev_word = '0; prev_stall = 1'b0;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
        step(); step();
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_word", 128'(out_word), 128'(0));
        chk("rst_flags", 128'({almost_full, overflow, out_last}), 128'(0));
        rst = 1'b0;
        step();

        // Single block at full rate.
        exp_x[0] = 32'h00112233; exp_x[1] = 32'h44556677;
        exp_x[2] = 32'h8899AABB; exp_x[3] = 32'hCCDDEEFF;
        in_data = BLK_X; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("x_word", 128'(out_word), 128'(exp_x[i]));
            chk("x_last", 128'(out_last), 128'(i == 3));
            step();
        end
        chk("x_count_empty", 128'(count), 128'(0));

        // Fill with sink stalled, then drop a fifth block.
        out_ready = 1'b0;
        seq4[0] = BLK_A; seq4[1] = BLK_B; seq4[2] = BLK_C; seq4[3] = BLK_D;
        for (int i = 0; i < 4; i++) begin
            in_data = seq4[i]; in_valid = 1'b1;
            step();
            chk("fill_count", 128'(count), 128'(i + 1));
            chk("fill_af", 128'(almost_full), 128'(i >= 1));
        end
        in_data = BLK_E;
        step();
        chk("drop_ovf", 128'(overflow), 128'(1));
        chk("drop_count", 128'(count), 128'(4));
        chk("drop_head", 128'(out_word), 128'(32'hA0A0A0A0));

        // Clear alone.
        in_valid = 1'b0; clear_overflow = 1'b1;
        step();
        chk("clear_alone", 128'(overflow), 128'(0));
        clear_overflow = 1'b0;

        // Advance to the last word of the head, then push while full with a pop.
        out_ready = 1'b1;
        step(); step(); step();
        chk("full_last", 128'(out_last), 128'(1));
        chk("full_last_word", 128'(out_word), 128'(32'hA3A3A3A3));
        in_data = BLK_F; in_valid = 1'b1;
        step();
        chk("pushpop_count", 128'(count), 128'(4));
        chk("pushpop_ovf", 128'(overflow), 128'(0));
        chk("pushpop_head", 128'(out_word), 128'(32'hB0B0B0B0));

        // Drop coinciding with clear keeps the flag set.
        out_ready = 1'b0; in_data = BLK_G;
        step();
        chk("drop2_ovf", 128'(overflow), 128'(1));
        clear_overflow = 1'b1;
        step();
        chk("clear_vs_drop", 128'(overflow), 128'(1));
        in_valid = 1'b0;
        step();
        chk("clear_after", 128'(overflow), 128'(0));
        clear_overflow = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("drain_tail", 128'(out_word), 128'(32'hF3F3F3F3));
        step();
        chk("drain_empty", 128'(count), 128'(0));

        // Eight blocks with a randomly stalling sink.
        for (int k = 0; k < 8; k++) blks[k] = {$urandom, $urandom, $urandom, $urandom};
        got.delete();
        begin
            int pushed;
            int cyc;
            pushed = 0;
            cyc = 0;
            while (got.size() < 32 && cyc < 600) begin
                in_valid  = (pushed < 8) && (q.size() < int'(DEPTH));
                in_data   = in_valid ? blks[pushed] : '0;
                out_ready = 1'($urandom_range(0, 1));
                if (in_valid) pushed++;
                step();
                cyc++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("rand_delivered", 128'(got.size()), 128'(32));
        for (int i = 0; i < 32 && i < got.size(); i++)
            chk("rand_order", 128'(got[i]), 128'(word_of(blks[i / 4], i % 4)));
        step();

        // Reset in the middle of a block.
        in_data = BLK_X; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("mid_word2", 128'(out_word), 128'(32'h8899AABB));
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_count", 128'(count), 128'(0));
        chk("mid_rst_word", 128'(out_word), 128'(0));
        rst = 1'b0;
        step();
        chk("mid_rst_stays", 128'(out_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
